// File: rtl/li_link_arbiter.sv
// Round-robin arbiter funnelling N latency-insensitive links into one,
// with burst framing and a two-entry relay-station output buffer.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   in_data_i     : per-requester data
//   in_valid_i    : per-requester valid
//   in_stop_o     : per-requester stop (decoded from registers only)
//   out_data_o    : shared output data (main register)
//   out_valid_o   : shared output valid (main register)
//   out_stop_i    : shared output stop from downstream
//   grant_id_o    : current or last granted requester
module li_link_arbiter #(
  parameter int WIDTH     = 6,
  parameter int N_INPUTS  = 4,
  parameter int BURST_MAX = 4,
  localparam int GW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_INPUTS-1:0][WIDTH-1:0] in_data_i,
  input  logic [N_INPUTS-1:0]           in_valid_i,
  output logic [N_INPUTS-1:0]           in_stop_o,
  output logic [WIDTH-1:0]              out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_stop_i,
  output logic [GW-1:0]                 grant_id_o
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e            state_q;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     rr_q;
  logic [BW-1:0]     burst_q;
  logic              main_valid_q;
  logic [WIDTH-1:0]  main_data_q;
  logic              aux_valid_q;
  logic [WIDTH-1:0]  aux_data_q;

  logic              hit;
  logic [GW-1:0]     hit_idx;
  logic [GW:0]       ssum;
  logic [GW-1:0]     sidx;
  logic              gnt_valid;
  logic [WIDTH-1:0]  gnt_data;
  logic              accept;
  logic              consume;
  logic              last_beat;
  logic [GW-1:0]     rr_d;

  // First valid requester at or after rr_q, wrapping.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    ssum    = '0;
    sidx    = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      ssum = {1'b0, rr_q} + (GW+1)'(k);
      if (ssum >= (GW+1)'(N_INPUTS))
        ssum = ssum - (GW+1)'(N_INPUTS);
      sidx = ssum[GW-1:0];
      if (!hit && in_valid_i[sidx]) begin
        hit     = 1'b1;
        hit_idx = sidx;
      end
    end
  end

  assign gnt_valid = in_valid_i[grant_q];
  assign gnt_data  = in_data_i[grant_q];
  // Granted stop equals aux_valid_q, so accept needs aux empty.
  assign accept    = (state_q == S_GRANT) && gnt_valid && !aux_valid_q;
  assign consume   = main_valid_q && !out_stop_i;
  assign last_beat = (burst_q == BW'(BURST_MAX-1));
  assign rr_d      = (grant_q == GW'(N_INPUTS-1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    in_stop_o = '1;
    if (state_q == S_GRANT)
      in_stop_o[grant_q] = aux_valid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      rr_q         <= '0;
      burst_q      <= '0;
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      aux_valid_q  <= 1'b0;
      aux_data_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hit) begin
            grant_q <= hit_idx;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          // A cycle with the granted stop raised never releases.
          if (!aux_valid_q) begin
            if (!gnt_valid || last_beat) begin
              state_q <= S_IDLE;
              rr_q    <= rr_d;
              burst_q <= '0;
            end else begin
              burst_q <= burst_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (accept) begin
        if (!main_valid_q || consume) begin
          main_data_q  <= gnt_data;
          main_valid_q <= 1'b1;
        end else begin
          aux_data_q  <= gnt_data;
          aux_valid_q <= 1'b1;
        end
      end else if (consume) begin
        if (aux_valid_q) begin
          main_data_q <= aux_data_q;
          aux_valid_q <= 1'b0;
        end else begin
          main_valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_data_o  = main_data_q;
  assign out_valid_o = main_valid_q;
  assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_li_link_arbiter.sv
// Bench for li_link_arbiter: queue-level reference model compared
// every cycle, directed scenarios pinned with literal expectations.
module tb_li_link_arbiter;
  localparam int W  = 6;
  localparam int N  = 4;
  localparam int B  = 4;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_stop;
  logic [W-1:0] out_data;
  logic out_valid;
  logic out_stop;
  logic [GW-1:0] grant_id;

  always #5 clk = ~clk;

  li_link_arbiter #(.WIDTH(W), .N_INPUTS(N), .BURST_MAX(B)) dut (
    .clk(clk),
    .reset(reset),
    .in_data_i(in_data),
    .in_valid_i(in_valid),
    .in_stop_o(in_stop),
    .out_data_o(out_data),
    .out_valid_o(out_valid),
    .out_stop_i(out_stop),
    .grant_id_o(grant_id)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: granted flag, grant, pointer, burst count,
  // and the buffer as a plain FIFO of at most two words.
  bit m_gnt;
  int m_g, m_ptr, m_cnt;
  int q[$];
  int obs[$];
  int ot[$];
  int gq[$];
  int cycle = 0;
  bit [N-1:0] fire;

  always @(negedge clk) begin
    cycle++;
    if (reset) begin
      m_gnt = 0; m_g = 0; m_ptr = 0; m_cnt = 0;
      q.delete();
      fire = '0;
    end else begin
      int sz;
      bit acc;
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
      for (int i = 0; i < N; i++)
        chk($sformatf("in_stop%0d", i), 32'(in_stop[i]),
            32'(!(m_gnt && m_g == i && q.size() < 2)));
      chk("grant_id", 32'(grant_id), 32'(m_g));
      if (out_valid && !out_stop) begin
        obs.push_back(int'(out_data));
        ot.push_back(cycle);
      end
      for (int i = 0; i < N; i++) fire[i] = in_valid[i] && !in_stop[i];
      sz  = q.size();
      acc = m_gnt && in_valid[m_g] && sz < 2;
      if (sz > 0 && !out_stop) void'(q.pop_front());
      if (acc) q.push_back(int'(in_data[m_g]));
      if (m_gnt) begin
        if (sz < 2) begin
          if (!in_valid[m_g] || m_cnt == B-1) begin
            m_gnt = 0; m_ptr = (m_g + 1) % N; m_cnt = 0;
          end else m_cnt++;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (!m_gnt && in_valid[idx]) begin
            m_gnt = 1; m_g = idx; gq.push_back(idx);
          end
        end
      end
    end
  end

  bit [N-1:0] en;
  int lim[N];
  int cnt[N];
  int vprob, sprob;
  bit force_stop;

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) cnt[i]++;
      if (!(in_valid[i] && !fire[i]))
        in_valid[i] = en[i] && cnt[i] < lim[i] &&
                      ($urandom_range(0, 99) < vprob);
      in_data[i] = W'(16 * i + (cnt[i] % 16));
    end
    out_stop = force_stop ? 1'b1 : ($urandom_range(0, 99) < sprob);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    in_valid = '0;
    out_stop = 1'b0;
    force_stop = 1'b0;
    en = '0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      lim[i] = 1000000;
      in_data[i] = W'(16 * i);
    end
    obs.delete(); ot.delete(); gq.delete();
  endtask

  task automatic setup(bit [N-1:0] e, int vp, int sp);
    en = e; vprob = vp; sprob = sp;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_stop = 1'b0;
    force_stop = 1'b0;
    en = '0;
    vprob = 0; sprob = 0;
    do_reset(2);
    chk("rst_out_data", 32'(out_data), 0);

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("idle_stop", 32'(in_stop), 32'hF);
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_grant", 32'(grant_id), 0);
    end

    // Single requester stream: 8 words, bubble after the 4th
    do_reset(1);
    lim[2] = 8;
    setup(4'b0100, 100, 0);
    repeat (24) cyc();
    chk("stream_n", obs.size(), 8);
    for (int k = 0; k < 8 && k < obs.size(); k++)
      chk($sformatf("stream_w%0d", k), obs[k], 32'h20 + k);
    if (ot.size() >= 5) begin
      chk("stream_gap01", ot[1] - ot[0], 1);
      chk("stream_bubble", ot[4] - ot[3], 2);
    end
    chk("stream_grants", gq.size(), 2);
    chk("stream_gid", 32'(grant_id), 2);

    // Fairness: all inputs always valid
    do_reset(1);
    setup(4'b1111, 100, 0);
    for (int c = 0; c < 60 && obs.size() < 17; c++) cyc();
    chk("fair_n", obs.size() >= 17, 1);
    for (int k = 0; k < 5 && k < gq.size(); k++)
      chk($sformatf("fair_g%0d", k), gq[k], k % 4);
    for (int k = 0; k < 16 && k < obs.size(); k++)
      chk($sformatf("fair_w%0d", k), obs[k], 16 * (k / 4) + (k % 4));
    if (obs.size() >= 17) chk("fair_w16", obs[16], 4);

    // Backpressure mid-burst
    do_reset(1);
    lim[0] = 12;
    setup(4'b0001, 100, 0);
    repeat (3) cyc();
    force_stop = 1'b1;
    repeat (5) cyc();
    chk("bp_stop0", 32'(in_stop[0]), 1);
    chk("bp_valid", 32'(out_valid), 1);
    force_stop = 1'b0;
    repeat (30) cyc();
    chk("bp_n", obs.size(), 12);
    for (int k = 0; k < 12 && k < obs.size(); k++)
      chk($sformatf("bp_w%0d", k), obs[k], k);

    // Early release: input 1 gives 2 words, input 3 waiting
    do_reset(1);
    lim[1] = 2;
    lim[3] = 4;
    setup(4'b1010, 100, 0);
    repeat (20) cyc();
    chk("er_grants", gq.size(), 2);
    if (gq.size() >= 2) begin
      chk("er_g0", gq[0], 1);
      chk("er_g1", gq[1], 3);
    end
    chk("er_n", obs.size(), 6);
    begin
      int exp_w[6] = '{8'h10, 8'h11, 8'h30, 8'h31, 8'h32, 8'h33};
      for (int k = 0; k < 6 && k < obs.size(); k++)
        chk($sformatf("er_w%0d", k), obs[k], exp_w[k]);
    end

    // Reset with two words buffered
    do_reset(1);
    setup(4'b0001, 100, 0);
    force_stop = 1'b1;
    repeat (5) cyc();
    chk("mr_pre_valid", 32'(out_valid), 1);
    chk("mr_pre_stop", 32'(in_stop[0]), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_data", 32'(out_data), 0);
    chk("mr_stop", 32'(in_stop), 32'hF);
    chk("mr_grant", 32'(grant_id), 0);
    reset = 1'b0;

    // Random traffic with occasional resets
    do_reset(1);
    setup(4'b1111, 60, 30);
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 250) begin
        sprob = $urandom_range(0, 80);
        vprob = $urandom_range(10, 100);
        en = 4'($urandom_range(1, 15));
      end
      reset = ($urandom_range(0, 399) == 0);
      cyc();
    end
    reset = 1'b0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
